// File: rtl/c5_niosii_spi_slvsec_niosii_cpu_button_if.sv
// Avalon-MM slave bus between the Nios II CPU and the button input PIO.
// The CPU side uses the master modport and the PIO uses the slave modport.
interface c5_niosii_spi_slvsec_niosii_cpu_button_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/c5_niosii_spi_slvsec_niosii_cpu_button.sv
// Button/status input PIO: synchronizer, sticky edge capture, irq mask, level irq.
// Define C5_NIOSII_BUTTON_BITCLEAR_EN so EDGECAPTURE writes clear only the 1 bits of writedata.
module c5_niosii_spi_slvsec_niosii_cpu_button #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [WIDTH-1:0]                        in_port,
  c5_niosii_spi_slvsec_niosii_cpu_button_if.slave avs
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] edge_detect;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] capture_clear;
  logic             irq_q;
  logic             wr_en;
  logic [31:0]      rd_data;
  logic             unused_writedata;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign wr_en  = avs.chipselect & ~avs.write_n;

  // Upper writedata bits have no register behind them.
  assign unused_writedata = ^avs.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
      d1      <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], in_port};
      d1      <= sync_q;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rising
      assign edge_detect = sync_q & ~d1;
    end else if (EDGE_TYPE == 1) begin : g_falling
      assign edge_detect = ~sync_q & d1;
    end else begin : g_any
      assign edge_detect = sync_q ^ d1;
    end
  endgenerate

  // Edge detect is ORed in last so a same-cycle set beats a clear.
  always_comb begin
    capture_clear = '0;
    if (wr_en && avs.address == 2'd3) begin
`ifdef C5_NIOSII_BUTTON_BITCLEAR_EN
      capture_clear = avs.writedata[WIDTH-1:0];
`else
      capture_clear = '1;
`endif
    end
    edge_capture_next = (edge_capture & ~capture_clear) | edge_detect;
  end

  always_comb begin
    irq_mask_next = irq_mask;
    if (wr_en && avs.address == 2'd2) begin
      irq_mask_next = avs.writedata[WIDTH-1:0];
    end
  end

  // irq looks at next-state values so it moves on the same edge as its sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
      irq_q        <= 1'b0;
    end else begin
      edge_capture <= edge_capture_next;
      irq_mask     <= irq_mask_next;
      irq_q        <= |(edge_capture_next & irq_mask_next);
    end
  end

  always_comb begin
    rd_data = '0;
    case (avs.address)
      2'd0:    rd_data[WIDTH-1:0] = sync_q;
      2'd2:    rd_data[WIDTH-1:0] = irq_mask;
      2'd3:    rd_data[WIDTH-1:0] = edge_capture;
      default: rd_data = '0;
    endcase
  end

  assign avs.readdata = rd_data;
  assign avs.irq      = irq_q;

endmodule

// File: tb/tb_c5_niosii_spi_slvsec_niosii_cpu_button.sv
// Self-checking bench for the button PIO against a sample-history reference model.
module tb_c5_niosii_spi_slvsec_niosii_cpu_button;
  localparam int WIDTH = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  // Reference model: hist[0] is the in_port value sampled at the latest edge.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_ec;
  logic [WIDTH-1:0] m_mask;
  logic             m_irq;

  c5_niosii_spi_slvsec_niosii_cpu_button_if bus ();

  c5_niosii_spi_slvsec_niosii_cpu_button #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .avs(bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back('0);
    m_ec = '0;
    m_mask = '0;
    m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr)
      2'd0: r[WIDTH-1:0] = hist[SYNC-1];
      2'd2: r[WIDTH-1:0] = m_mask;
      2'd3: r[WIDTH-1:0] = m_ec;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance one clock; the model sees exactly the inputs present at the edge.
  task automatic cycle();
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic             wr;
    @(posedge clk);
    if (reset_n) begin
      rise = hist[SYNC-1] & ~hist[SYNC];
      wr = bus.chipselect && !bus.write_n;
      clr = '0;
      if (wr && bus.address == 2'd3) begin
`ifdef C5_NIOSII_BUTTON_BITCLEAR_EN
        clr = bus.writedata[WIDTH-1:0];
`else
        clr = '1;
`endif
      end
      if (wr && bus.address == 2'd2) m_mask = bus.writedata[WIDTH-1:0];
      m_ec = (m_ec & ~clr) | rise;
      m_irq = |(m_ec & m_mask);
      hist.push_front(in_port);
      hist.pop_back();
    end
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.address = addr;
    bus.writedata = data;
    cycle();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic read_expect(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    bus.address = addr;
    #1;
    got = bus.readdata;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: readdata=0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 2'd0;
    bus.writedata = '0;
    in_port = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    for (int a = 0; a < 4; a++) read_expect("reset_read", 2'(a), 32'h0);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_irq: irq=%b expected 0", bus.irq);
    end
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_latency();
    in_port = 4'b0101;
    cycle();
    read_expect("data_after_1", 2'd0, 32'h0);
    cycle();
    read_expect("data_after_2", 2'd0, 32'h5);
    read_expect("ec_after_2", 2'd3, 32'h0);
    cycle();
    read_expect("ec_after_3", 2'd3, 32'h5);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL irq_masked: irq=%b expected 0", bus.irq);
    end
  endtask

  task automatic test_mask_irq();
    bus_write(2'd2, 32'h4);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL irq_mask4: irq=%b expected 1", bus.irq);
    end
    read_expect("mask_read", 2'd2, 32'h4);
    bus_write(2'd2, 32'h2);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL irq_mask2: irq=%b expected 0", bus.irq);
    end
  endtask

  task automatic test_clear();
    bus_write(2'd3, 32'h1);
`ifdef C5_NIOSII_BUTTON_BITCLEAR_EN
    read_expect("bit_clear", 2'd3, 32'h4);
`else
    read_expect("clear_all", 2'd3, 32'h0);
`endif
    bus_write(2'd3, 32'hF);
    read_expect("cleared", 2'd3, 32'h0);
  endtask

  task automatic test_set_wins();
    in_port = 4'b0111;
    cycle();
    cycle();
    bus_write(2'd3, 32'hF);
    read_expect("set_wins", 2'd3, 32'h2);
    read_expect("set_wins_model", 2'd3, model_read(2'd3));
  endtask

  task automatic test_random();
    logic [1:0] raddr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = WIDTH'($urandom);
      bus.chipselect = 1'($urandom);
      bus.write_n = ($urandom_range(0, 3) != 0);
      bus.address = 2'($urandom);
      bus.writedata = $urandom;
      cycle();
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      raddr = 2'($urandom);
      read_expect("random_read", raddr, model_read(raddr));
      n_checks++;
      if (bus.irq !== m_irq) begin
        n_fail++;
        $display("[TB] FAIL random_irq: irq=%b expected %b at iter %0d", bus.irq, m_irq, i);
      end
    end
  endtask

  task automatic test_async_reset();
    bus_write(2'd2, 32'hF);
    in_port = 4'h0;
    repeat (4) cycle();
    in_port = 4'hF;
    repeat (4) cycle();
    read_expect("ec_full", 2'd3, 32'hF);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL irq_before_reset: irq=%b expected 1", bus.irq);
    end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL irq_async_reset: irq=%b expected 0", bus.irq);
    end
    read_expect("ec_async_reset", 2'd3, 32'h0);
    read_expect("mask_async_reset", 2'd2, 32'h0);
    read_expect("data_async_reset", 2'd0, 32'h0);
    cycle();
    reset_n = 1'b1;
    // in_port held high through reset: capture appears SYNC+1 edges later.
    repeat (SYNC) cycle();
    read_expect("held_no_capture", 2'd3, 32'h0);
    cycle();
    read_expect("held_capture", 2'd3, 32'hF);
    read_expect("held_capture_model", 2'd3, model_read(2'd3));
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mask_irq();
    test_clear();
    test_set_wins();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
